pwm_mc: RTL and testbench

Multi-channel, parametrised PWM generator. All channels share one prescaled counter. It supports edge-aligned or center-aligned modes. Duty and mode updates are double-buffered so they take effect only at a period boundary, which gives glitch-free updates. It sits between a register/control interface and the pin drivers (LED, motor, DAC-filter outputs).

---
 rtl/pwm_mc.sv | 131 +++++++++++++
 tb/tb_pwm_mc.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_mc.sv
// Multi-channel PWM generator sharing one prescaled counter, edge- or center-aligned,
// with duty/mode double-buffered so updates land only on a period boundary.
module pwm_mc #(
   parameter int N     = 8,
   parameter int CH    = 4,
   parameter int PSC_W = 8
) (
   input  logic              clk_i,
   input  logic              resetn_i,
   input  logic              en_i,
   input  logic              mode_i,
   input  logic [PSC_W-1:0]  psc_i,
   input  logic [CH*N-1:0]   duty_i,
   input  logic              load_i,
   output logic              pending_o,
   output logic              period_o,
   output logic [CH-1:0]     pwm_o
);

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   localparam logic [N-1:0]     CntMax = {N{1'b1}};
   localparam logic [N-1:0]     CntOne = N'(1);
   localparam logic [PSC_W-1:0] PscOne = PSC_W'(1);

   logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;
   logic [N-1:0]     cnt_q, cnt_d;
   dir_e             dir_q, dir_d;
   logic [CH*N-1:0]  shadow_duty_q;
   logic             shadow_mode_q;
   logic [CH*N-1:0]  act_duty_q;
   logic             act_mode_q;
   logic             pending_q, pending_d;
   logic             period_q;
   logic [CH-1:0]    pwm_q, pwm_d;
   logic             tick;
   logic             boundary;
   logic             apply;

   always_comb begin
      tick      = en_i && (psc_cnt_q == psc_i);
      psc_cnt_d = (!en_i || tick) ? '0 : psc_cnt_q + PscOne;

      cnt_d    = cnt_q;
      dir_d    = dir_q;
      boundary = 1'b0;

      if (!en_i) begin
         cnt_d = '0;
         dir_d = DIR_UP;
      end else if (tick) begin
         if (!act_mode_q) begin
            cnt_d    = cnt_q + CntOne;
            boundary = (cnt_q == CntMax);
         end else if (dir_q == DIR_UP) begin
            if (cnt_q == CntMax) begin
               cnt_d = cnt_q - CntOne;
               dir_d = DIR_DOWN;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end else begin
            cnt_d = cnt_q - CntOne;
            if (cnt_q == CntOne) begin
               dir_d    = DIR_UP;
               boundary = 1'b1;
            end
         end
      end

      // Every period (and any mode switch) restarts from 0 counting up.
      if (boundary) begin
         cnt_d = '0;
         dir_d = DIR_UP;
      end

      // While disabled the shadow is pushed through immediately so a restart uses fresh values.
      apply     = pending_q && (!en_i || boundary);
      pending_d = pending_q;
      if (apply) begin
         pending_d = 1'b0;
      end
      if (load_i) begin
         pending_d = 1'b1;
      end

      pwm_d = '0;
      for (int k = 0; k < CH; k++) begin
         pwm_d[k] = en_i && (cnt_q < act_duty_q[k*N +: N]);
      end
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         psc_cnt_q     <= '0;
         cnt_q         <= '0;
         dir_q         <= DIR_UP;
         shadow_duty_q <= '0;
         shadow_mode_q <= 1'b0;
         act_duty_q    <= '0;
         act_mode_q    <= 1'b0;
         pending_q     <= 1'b0;
         period_q      <= 1'b0;
         pwm_q         <= '0;
      end else begin
         psc_cnt_q <= psc_cnt_d;
         cnt_q     <= cnt_d;
         dir_q     <= dir_d;
         pending_q <= pending_d;
         period_q  <= boundary;
         pwm_q     <= pwm_d;
         if (load_i) begin
            shadow_duty_q <= duty_i;
            shadow_mode_q <= mode_i;
         end
         if (apply) begin
            act_duty_q <= shadow_duty_q;
            act_mode_q <= shadow_mode_q;
         end
      end
   end

   // Gating keeps a boundary pulse from leaking into the first disabled cycle.
   assign period_o  = period_q & en_i;
   assign pending_o = pending_q;
   assign pwm_o     = pwm_q;

endmodule

// File: tb/tb_pwm_mc.sv
// Directed testbench for pwm_mc at N=4, CH=2; samples and drives on the falling clock edge.
module tb_pwm_mc;

   localparam int N     = 4;
   localparam int CH    = 2;
   localparam int PSC_W = 8;

   logic              clk_i = 1'b0;
   logic              resetn_i;
   logic              en_i;
   logic              mode_i;
   logic [PSC_W-1:0]  psc_i;
   logic [CH*N-1:0]   duty_i;
   logic              load_i;
   logic              pending_o;
   logic              period_o;
   logic [CH-1:0]     pwm_o;

   int total = 0;
   int bad   = 0;

   pwm_mc #(.N(N), .CH(CH), .PSC_W(PSC_W)) dut (
      .clk_i     (clk_i),
      .resetn_i  (resetn_i),
      .en_i      (en_i),
      .mode_i    (mode_i),
      .psc_i     (psc_i),
      .duty_i    (duty_i),
      .load_i    (load_i),
      .pending_o (pending_o),
      .period_o  (period_o),
      .pwm_o     (pwm_o)
   );

   always #5 clk_i = ~clk_i;

   // Advances to the next falling edge on which period_o is high, bounded.
   task automatic waitPeriod(input string tag);
      int n;
      n = 0;
      @(negedge clk_i);
      while (!period_o && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      total++;
      if (!period_o) begin
         bad++;
         $display("[TB] FAIL %s period_o timeout: got=0 want=1", tag);
      end
   endtask

   // Samples ncyc falling edges, the current one included.
   task automatic measure(input int ncyc, output int hi0, output int hi1, output int per);
      hi0 = 0;
      hi1 = 0;
      per = 0;
      for (int i = 0; i < ncyc; i++) begin
         if (i > 0) @(negedge clk_i);
         hi0 += int'(pwm_o[0]);
         hi1 += int'(pwm_o[1]);
         per += int'(period_o);
      end
   endtask

   task automatic loadDuty(input int d0, input int d1, input logic m);
      duty_i = {N'(d1), N'(d0)};
      mode_i = m;
      load_i = 1'b1;
      @(negedge clk_i);
      load_i = 1'b0;
   endtask

   task automatic test_reset;
      resetn_i = 1'b0;
      repeat (3) @(negedge clk_i);
      total++; if (pwm_o !== 2'b00) begin bad++; $display("[TB] FAIL reset_pwm got=%b want=00", pwm_o); end
      total++; if (period_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_period got=%b want=0", period_o); end
      total++; if (pending_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_pending got=%b want=0", pending_o); end
      resetn_i = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic test_edge_basic;
      int hi0, hi1, per;
      loadDuty(4, 0, 1'b0);
      total++; if (pending_o !== 1'b1) begin bad++; $display("[TB] FAIL basic_pending_set got=%b want=1", pending_o); end
      @(negedge clk_i);
      total++; if (pending_o !== 1'b0) begin bad++; $display("[TB] FAIL basic_pending_clr got=%b want=0", pending_o); end
      en_i = 1'b1;
      waitPeriod("basic_sync");
      measure(16, hi0, hi1, per);
      total++; if (hi0 !== 4) begin bad++; $display("[TB] FAIL basic_hi0 got=%0d want=4", hi0); end
      total++; if (hi1 !== 0) begin bad++; $display("[TB] FAIL basic_hi1 got=%0d want=0", hi1); end
      total++; if (per !== 1) begin bad++; $display("[TB] FAIL basic_per_count got=%0d want=1", per); end
      @(negedge clk_i);
      total++; if (period_o !== 1'b1) begin bad++; $display("[TB] FAIL basic_per_spacing got=%b want=1", period_o); end
   endtask

   task automatic test_prescaler;
      int hi0, hi1, per;
      psc_i = 8'd2;
      waitPeriod("psc_sync");
      measure(48, hi0, hi1, per);
      total++; if (hi0 !== 12) begin bad++; $display("[TB] FAIL psc_hi0 got=%0d want=12", hi0); end
      total++; if (per !== 1) begin bad++; $display("[TB] FAIL psc_per_count got=%0d want=1", per); end
      @(negedge clk_i);
      total++; if (period_o !== 1'b1) begin bad++; $display("[TB] FAIL psc_per_spacing got=%b want=1", period_o); end
      psc_i = 8'd0;
   endtask

   task automatic test_full_duty;
      int hi0, hi1, per;
      loadDuty(15, 1, 1'b0);
      waitPeriod("full_sync");
      measure(16, hi0, hi1, per);
      total++; if (hi0 !== 15) begin bad++; $display("[TB] FAIL full_hi0 got=%0d want=15", hi0); end
      total++; if (hi1 !== 1) begin bad++; $display("[TB] FAIL full_hi1 got=%0d want=1", hi1); end
   endtask

   task automatic test_back_to_back;
      int hi[4];
      int per;
      logic pend[64];
      loadDuty(8, 0, 1'b0);
      waitPeriod("b2b_sync");
      per = 0;
      for (int p = 0; p < 4; p++) hi[p] = 0;
      for (int i = 0; i < 64; i++) begin
         if (i > 0) @(negedge clk_i);
         hi[i / 16] += int'(pwm_o[0]);
         per += int'(period_o);
         pend[i] = pending_o;
         load_i = 1'b0;
         if (i == 5)  begin duty_i = {N'(0), N'(2)}; load_i = 1'b1; end
         if (i == 19) begin duty_i = {N'(0), N'(6)}; load_i = 1'b1; end
         if (i == 31) begin duty_i = {N'(0), N'(3)}; load_i = 1'b1; end
      end
      total++; if (hi[0] !== 8) begin bad++; $display("[TB] FAIL b2b_hi_p0 got=%0d want=8", hi[0]); end
      total++; if (pend[6] !== 1'b1) begin bad++; $display("[TB] FAIL b2b_pend6 got=%b want=1", pend[6]); end
      total++; if (pend[15] !== 1'b1) begin bad++; $display("[TB] FAIL b2b_pend15 got=%b want=1", pend[15]); end
      total++; if (pend[16] !== 1'b0) begin bad++; $display("[TB] FAIL b2b_pend16 got=%b want=0", pend[16]); end
      total++; if (hi[1] !== 2) begin bad++; $display("[TB] FAIL b2b_hi_p1 got=%0d want=2", hi[1]); end
      total++; if (pend[32] !== 1'b1) begin bad++; $display("[TB] FAIL b2b_pend32_deferred got=%b want=1", pend[32]); end
      total++; if (hi[2] !== 6) begin bad++; $display("[TB] FAIL b2b_hi_p2 got=%0d want=6", hi[2]); end
      total++; if (pend[48] !== 1'b0) begin bad++; $display("[TB] FAIL b2b_pend48 got=%b want=0", pend[48]); end
      total++; if (hi[3] !== 3) begin bad++; $display("[TB] FAIL b2b_hi_p3 got=%0d want=3", hi[3]); end
      total++; if (per !== 4) begin bad++; $display("[TB] FAIL b2b_per_count got=%0d want=4", per); end
   endtask

   task automatic test_center;
      int hi0, hi1, per;
      loadDuty(4, 0, 1'b1);
      waitPeriod("center_sync");
      // First center period still sees the last edge-mode count (15) in its opening sample.
      measure(30, hi0, hi1, per);
      total++; if (hi0 !== 6) begin bad++; $display("[TB] FAIL center_first_hi0 got=%0d want=6", hi0); end
      @(negedge clk_i);
      total++; if (period_o !== 1'b1) begin bad++; $display("[TB] FAIL center_spacing1 got=%b want=1", period_o); end
      measure(30, hi0, hi1, per);
      total++; if (hi0 !== 7) begin bad++; $display("[TB] FAIL center_hi0 got=%0d want=7", hi0); end
      total++; if (hi1 !== 0) begin bad++; $display("[TB] FAIL center_hi1 got=%0d want=0", hi1); end
      total++; if (per !== 1) begin bad++; $display("[TB] FAIL center_per_count got=%0d want=1", per); end
      @(negedge clk_i);
      total++; if (period_o !== 1'b1) begin bad++; $display("[TB] FAIL center_spacing2 got=%b want=1", period_o); end
   endtask

   task automatic test_disable;
      int hi0, hi1, per;
      @(negedge clk_i);
      total++; if (pwm_o[0] !== 1'b1) begin bad++; $display("[TB] FAIL dis_pre_high got=%b want=1", pwm_o[0]); end
      en_i = 1'b0;
      @(negedge clk_i);
      total++; if (pwm_o !== 2'b00) begin bad++; $display("[TB] FAIL dis_pwm_low got=%b want=00", pwm_o); end
      total++; if (period_o !== 1'b0) begin bad++; $display("[TB] FAIL dis_period got=%b want=0", period_o); end
      duty_i = {N'(0), N'(10)};
      mode_i = 1'b0;
      load_i = 1'b1;
      @(negedge clk_i);
      load_i = 1'b0;
      total++; if (pending_o !== 1'b1) begin bad++; $display("[TB] FAIL dis_pending_set got=%b want=1", pending_o); end
      @(negedge clk_i);
      total++; if (pending_o !== 1'b0) begin bad++; $display("[TB] FAIL dis_pending_clr got=%b want=0", pending_o); end
      en_i = 1'b1;
      @(negedge clk_i);
      measure(15, hi0, hi1, per);
      total++; if (hi0 !== 10) begin bad++; $display("[TB] FAIL dis_first_hi0 got=%0d want=10", hi0); end
      total++; if (per !== 0) begin bad++; $display("[TB] FAIL dis_early_period got=%0d want=0", per); end
      @(negedge clk_i);
      total++; if (period_o !== 1'b1) begin bad++; $display("[TB] FAIL dis_first_boundary got=%b want=1", period_o); end
   endtask

   task automatic test_async_reset;
      int hi0, hi1, per;
      int pwmSeen, pendSeen;
      loadDuty(5, 0, 1'b0);
      @(negedge clk_i);
      total++; if (pwm_o[0] !== 1'b1) begin bad++; $display("[TB] FAIL rst_pre_high got=%b want=1", pwm_o[0]); end
      total++; if (pending_o !== 1'b1) begin bad++; $display("[TB] FAIL rst_pre_pending got=%b want=1", pending_o); end
      #2 resetn_i = 1'b0;
      #1;
      total++; if (pwm_o !== 2'b00) begin bad++; $display("[TB] FAIL rst_async_pwm got=%b want=00", pwm_o); end
      total++; if (pending_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_async_pending got=%b want=0", pending_o); end
      total++; if (period_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_async_period got=%b want=0", period_o); end
      repeat (2) @(negedge clk_i);
      resetn_i = 1'b1;
      pwmSeen  = 0;
      pendSeen = 0;
      per      = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_i);
         pwmSeen  += int'(pwm_o != 2'b00);
         pendSeen += int'(pending_o);
         per      += int'(period_o);
      end
      total++; if (pwmSeen !== 0) begin bad++; $display("[TB] FAIL rst_pwm_idle got=%0d want=0", pwmSeen); end
      total++; if (pendSeen !== 0) begin bad++; $display("[TB] FAIL rst_pending_idle got=%0d want=0", pendSeen); end
      total++; if (per !== 2) begin bad++; $display("[TB] FAIL rst_period_count got=%0d want=2", per); end
      loadDuty(3, 0, 1'b0);
      waitPeriod("rst_sync");
      measure(16, hi0, hi1, per);
      total++; if (hi0 !== 3) begin bad++; $display("[TB] FAIL rst_new_hi0 got=%0d want=3", hi0); end
   endtask

   initial begin
      resetn_i = 1'b0;
      en_i     = 1'b0;
      mode_i   = 1'b0;
      psc_i    = '0;
      duty_i   = '0;
      load_i   = 1'b0;
      test_reset();
      test_edge_basic();
      test_prescaler();
      test_full_duty();
      test_back_to_back();
      test_center();
      test_disable();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
